// File: rtl/life_grid_engine_pkg.sv
// Shared types and rule constants for the cellular-automaton grid engine.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVOLVE = 2'd1,
    CHECK  = 2'd2,
    HALTED = 2'd3
  } life_state_e;

  localparam logic [8:0] RULE_B3S23_BIRTH   = 9'h008;
  localparam logic [8:0] RULE_B3S23_SURV    = 9'h00C;
  localparam logic [8:0] RULE_HIGHLIFE_BIRTH = 9'h048;
  localparam logic [8:0] RULE_HIGHLIFE_SURV  = 9'h00C;

endpackage

// File: rtl/life_grid_engine_if.sv
// Control, load and status bundle between the input logic, the engine and the display driver.
interface life_grid_engine_if #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int GEN_W = 16
);
  logic                       run;
  logic                       tick;
  logic                       step;
  logic                       wrap_en;
  logic                       load_valid;
  logic                       load_ready;
  logic [ROWS-1:0][COLS-1:0]  user_grid;
  logic [ROWS-1:0][COLS-1:0]  cell_status;
  logic [GEN_W-1:0]           generation;
  logic                       stable;
  logic                       extinct;
  logic                       halted;

  modport master (
    output run, tick, step, wrap_en, load_valid, user_grid,
    input  load_ready, cell_status, generation, stable, extinct, halted
  );

  modport slave (
    input  run, tick, step, wrap_en, load_valid, user_grid,
    output load_ready, cell_status, generation, stable, extinct, halted
  );
endinterface

// File: rtl/life_grid_engine_cell_next.sv
// Per-cell successor rule: counts live neighbours and looks the result up in the birth/survive masks.
module life_cell_next (
  input  logic [7:0] nbrs,
  input  logic       alive,
  input  logic [8:0] birth_mask,
  input  logic [8:0] surv_mask,
  output logic       next
);

  logic [3:0] cnt_s;

  // Population count of the eight neighbours, then rule lookup.
  always_comb begin
    cnt_s = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt_s = cnt_s + {3'b000, nbrs[i]};
    end
    if (alive) begin
      next = surv_mask[cnt_s];
    end else begin
      next = birth_mask[cnt_s];
    end
  end

endmodule

// File: rtl/life_grid_engine.sv
// Cellular-automaton grid engine: load handshake, step/free-run sequencing, generation count,
// stable/extinct detection with optional auto-halt.
module life_grid_engine
  import life_pkg::*;
#(
  parameter int         ROWS       = 16,
  parameter int         COLS       = 16,
  parameter logic [8:0] BIRTH_MASK = RULE_B3S23_BIRTH,
  parameter logic [8:0] SURV_MASK  = RULE_B3S23_SURV,
  parameter int         GEN_W      = 16,
  parameter bit         AUTO_HALT  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  life_grid_engine_if.slave   bus
);

  if (ROWS < 3 || COLS < 3) begin : g_bad_size
    $error("life_grid_engine: ROWS and COLS must both be at least 3");
  end

  life_state_e               state_r, next_state_s;
  logic [ROWS-1:0][COLS-1:0] grid_r, prev_r, next_grid_s;
  logic [GEN_W-1:0]          gen_r;
  logic                      stable_r, extinct_r, run_d_r;
  logic                      load_ready_s, load_acc_s, run_fall_s;
  logic                      stable_nx_s, extinct_nx_s;

  // Edge cells only see their wrapped-around neighbour when the torus is enabled.
  function automatic logic nbr_sel(input logic bit_v, input logic edge_v, input logic wrap);
    return bit_v & (wrap | ~edge_v);
  endfunction

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int RU = (r == 0) ? ROWS - 1 : r - 1;
      localparam int RD = (r == ROWS - 1) ? 0 : r + 1;
      localparam int CL = (c == 0) ? COLS - 1 : c - 1;
      localparam int CR = (c == COLS - 1) ? 0 : c + 1;
      localparam bit EU = (r == 0);
      localparam bit ED = (r == ROWS - 1);
      localparam bit EL = (c == 0);
      localparam bit ER = (c == COLS - 1);
      logic [7:0] nb_s;

      assign nb_s[0] = nbr_sel(grid_r[RU][CL], EU | EL, bus.wrap_en);
      assign nb_s[1] = nbr_sel(grid_r[RU][c],  EU,      bus.wrap_en);
      assign nb_s[2] = nbr_sel(grid_r[RU][CR], EU | ER, bus.wrap_en);
      assign nb_s[3] = nbr_sel(grid_r[r][CL],  EL,      bus.wrap_en);
      assign nb_s[4] = nbr_sel(grid_r[r][CR],  ER,      bus.wrap_en);
      assign nb_s[5] = nbr_sel(grid_r[RD][CL], ED | EL, bus.wrap_en);
      assign nb_s[6] = nbr_sel(grid_r[RD][c],  ED,      bus.wrap_en);
      assign nb_s[7] = nbr_sel(grid_r[RD][CR], ED | ER, bus.wrap_en);

      life_cell_next u_cell (
        .nbrs       (nb_s),
        .alive      (grid_r[r][c]),
        .birth_mask (BIRTH_MASK),
        .surv_mask  (SURV_MASK),
        .next       (next_grid_s[r][c])
      );
    end
  end

  assign load_ready_s = (state_r == IDLE) || (state_r == HALTED);
  assign load_acc_s   = bus.load_valid & load_ready_s;
  assign run_fall_s   = run_d_r & ~bus.run;
  assign stable_nx_s  = (grid_r == prev_r);
  assign extinct_nx_s = (grid_r == '0);

  // Next-state logic; load always wins over any advance request.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.load_valid) begin
          next_state_s = IDLE;
        end else if (bus.step || (bus.run && bus.tick)) begin
          next_state_s = EVOLVE;
        end else begin
          next_state_s = IDLE;
        end
      end
      EVOLVE: next_state_s = CHECK;
      CHECK: begin
        if (AUTO_HALT && (stable_nx_s || extinct_nx_s)) begin
          next_state_s = HALTED;
        end else begin
          next_state_s = IDLE;
        end
      end
      HALTED: begin
        if (bus.load_valid || run_fall_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = HALTED;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register and run history for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      run_d_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      run_d_r <= bus.run;
    end
  end

  // Grid, history, generation counter and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grid_r    <= '0;
      prev_r    <= '0;
      gen_r     <= '0;
      stable_r  <= 1'b0;
      extinct_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE, HALTED: begin
          if (load_acc_s) begin
            grid_r    <= bus.user_grid;
            gen_r     <= '0;
            stable_r  <= 1'b0;
            extinct_r <= (bus.user_grid == '0);
          end
        end
        EVOLVE: begin
          prev_r <= grid_r;
          grid_r <= next_grid_s;
          gen_r  <= gen_r + {{(GEN_W-1){1'b0}}, 1'b1};
        end
        CHECK: begin
          stable_r  <= stable_nx_s;
          extinct_r <= extinct_nx_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.load_ready  = load_ready_s;
  assign bus.cell_status = grid_r;
  assign bus.generation  = gen_r;
  assign bus.stable      = stable_r;
  assign bus.extinct     = extinct_r;
  assign bus.halted      = (state_r == HALTED);

endmodule

// File: tb/tb_life_grid_engine.sv
// Directed self-checking bench for life_grid_engine (16x16, B3/S23, auto-halt on).
module tb_life_grid_engine;
  import life_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  life_grid_engine_if #(.ROWS(16), .COLS(16), .GEN_W(16)) bus ();

  life_grid_engine #(
    .ROWS(16), .COLS(16), .BIRTH_MASK(RULE_B3S23_BIRTH), .SURV_MASK(RULE_B3S23_SURV),
    .GEN_W(16), .AUTO_HALT(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_grid(input logic [15:0][15:0] g);
    bus.user_grid  = g;
    bus.load_valid = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic step_once();
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic tick_once();
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  logic [15:0][15:0] g, e, glider;
  logic saw_halt;

  initial begin
    checks = 0;
    errors = 0;
    bus.run = 1'b0; bus.tick = 1'b0; bus.step = 1'b0; bus.wrap_en = 1'b1;
    bus.load_valid = 1'b0; bus.user_grid = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_grid", 256'(bus.cell_status), 256'd0);
    check_val("rst_gen", 256'(bus.generation), 256'd0);
    check_val("rst_flags", 256'({bus.stable, bus.extinct, bus.halted, bus.load_ready}), 256'(4'b0101));
    rst_n = 1'b1;
    @(negedge clk);

    // Horizontal blinker straddling the column seam becomes vertical across the row seam.
    g = '0; g[0][15] = 1'b1; g[0][0] = 1'b1; g[0][1] = 1'b1;
    load_grid(g);
    check_val("t1_load", 256'(bus.cell_status), 256'(g));
    check_val("t1_load_ext", 256'(bus.extinct), 256'd0);
    step_once();
    e = '0; e[15][0] = 1'b1; e[0][0] = 1'b1; e[1][0] = 1'b1;
    check_val("t1_grid", 256'(bus.cell_status), 256'(e));
    check_val("t1_gen", 256'(bus.generation), 256'd1);
    check_val("t1_flags", 256'({bus.stable, bus.extinct, bus.halted}), 256'd0);

    // Dead border: row 0 cols 13..15.
    bus.wrap_en = 1'b0;
    g = '0; g[0][13] = 1'b1; g[0][14] = 1'b1; g[0][15] = 1'b1;
    load_grid(g);
    check_val("t3_gen0", 256'(bus.generation), 256'd0);
    step_once();
    e = '0; e[0][14] = 1'b1; e[1][14] = 1'b1;
    check_val("t3_grid", 256'(bus.cell_status), 256'(e));

    // Glider on the torus returns home after 64 generations.
    bus.wrap_en = 1'b1;
    glider = '0;
    glider[0][1] = 1'b1; glider[1][2] = 1'b1;
    glider[2][0] = 1'b1; glider[2][1] = 1'b1; glider[2][2] = 1'b1;
    load_grid(glider);
    bus.run = 1'b1;
    saw_halt = 1'b0;
    for (int k = 0; k < 64; k++) begin
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      saw_halt = saw_halt | bus.halted;
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        saw_halt = saw_halt | bus.halted;
      end
      if (k == 0) begin
        check_val("t2_gen1_moved", 256'(bus.cell_status != glider), 256'd1);
      end
    end
    bus.run = 1'b0;
    repeat (2) @(negedge clk);
    check_val("t2_grid", 256'(bus.cell_status), 256'(glider));
    check_val("t2_gen", 256'(bus.generation), 256'd64);
    check_val("t2_never_halt", 256'(saw_halt), 256'd0);

    // Still life: block halts after the first generation.
    g = '0; g[5][5] = 1'b1; g[5][6] = 1'b1; g[6][5] = 1'b1; g[6][6] = 1'b1;
    load_grid(g);
    bus.run = 1'b1;
    tick_once();
    check_val("t4_flags", 256'({bus.stable, bus.halted, bus.load_ready}), 256'(3'b111));
    check_val("t4_gen", 256'(bus.generation), 256'd1);
    tick_once();
    tick_once();
    check_val("t4_gen_hold", 256'(bus.generation), 256'd1);
    check_val("t4_still_halt", 256'(bus.halted), 256'd1);
    bus.run = 1'b0;
    repeat (2) @(negedge clk);
    check_val("t4_unhalt", 256'(bus.halted), 256'd0);
    check_val("t4_grid_kept", 256'(bus.cell_status), 256'(g));

    // Lone cell dies; step is ignored while halted; load beats a same-cycle step.
    g = '0; g[8][8] = 1'b1;
    load_grid(g);
    step_once();
    check_val("t5_ext_halt", 256'({bus.extinct, bus.halted}), 256'(2'b11));
    check_val("t5_gen", 256'(bus.generation), 256'd1);
    step_once();
    check_val("t5_halt_step", 256'({bus.generation, bus.halted}), 256'({16'd1, 1'b1}));
    g = '0; g[4][3] = 1'b1; g[4][4] = 1'b1; g[4][5] = 1'b1;
    bus.user_grid = g; bus.load_valid = 1'b1; bus.step = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0; bus.step = 1'b0;
    repeat (4) @(negedge clk);
    check_val("t5_load_grid", 256'(bus.cell_status), 256'(g));
    check_val("t5_load_gen", 256'(bus.generation), 256'd0);
    check_val("t5_load_flags", 256'({bus.extinct, bus.halted}), 256'd0);

    // Asynchronous reset in the middle of an evolve.
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_rst_grid", 256'(bus.cell_status), 256'd0);
    check_val("t6_rst_misc", 256'({bus.generation, bus.extinct, bus.halted, bus.load_ready}),
              256'({16'd0, 1'b1, 1'b0, 1'b1}));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_grid(g);
    step_once();
    e = '0; e[3][4] = 1'b1; e[4][4] = 1'b1; e[5][4] = 1'b1;
    check_val("t6_after", 256'(bus.cell_status), 256'(e));
    check_val("t6_gen", 256'(bus.generation), 256'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
